// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with a frame-latched RGB test pattern.
// Outputs are registered one cycle behind the (h_cnt, v_cnt) position they decode.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int COLOR_BITS = 3,
    parameter int GRID_LOG2  = 4,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [1:0]            pattern_sel,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  frame_start,
    output logic                  line_start
);

    localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG    = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG    = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);

    // Bar index is tracked by a pixel-in-bar counter so no divider is needed.
    localparam int             BAR_W    = H_ACTIVE / 8;
    localparam int             BCW      = $clog2(BAR_W + 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    localparam int XSH = (XW > COLOR_BITS) ? XW - COLOR_BITS : 0;
    localparam int YSH = (YW > COLOR_BITS) ? YW - COLOR_BITS : 0;

    logic [XW-1:0]         h_cnt;
    logic [YW-1:0]         v_cnt;
    logic [BCW-1:0]        bar_pix;
    logic [2:0]            bar_idx;
    logic [1:0]            pat_q;

    logic                  at_origin;
    logic                  h_last;
    logic                  v_last;
    logic [1:0]            pat_now;
    logic                  active;
    logic                  hs_on;
    logic                  vs_on;
    logic [2:0]            bar_rgb;
    logic [COLOR_BITS-1:0] nxt_r;
    logic [COLOR_BITS-1:0] nxt_g;
    logic [COLOR_BITS-1:0] nxt_b;

    // Pixel (0,0) already uses the pattern being latched on the same edge.
    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        pat_now   = at_origin ? pattern_sel : pat_q;
        active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        bar_rgb   = 3'd7 - bar_idx;
        nxt_r     = '0;
        nxt_g     = '0;
        nxt_b     = '0;
        if (active) begin
            case (pat_now)
                2'd1: begin
                    nxt_r = {COLOR_BITS{bar_rgb[2]}};
                    nxt_g = {COLOR_BITS{bar_rgb[1]}};
                    nxt_b = {COLOR_BITS{bar_rgb[0]}};
                end
                2'd2: begin
                    if ((h_cnt[GRID_LOG2-1:0] == '0) || (v_cnt[GRID_LOG2-1:0] == '0)) begin
                        nxt_r = '1;
                        nxt_g = '1;
                        nxt_b = '1;
                    end
                end
                2'd3: begin
                    nxt_r = COLOR_BITS'(h_cnt >> XSH);
                    nxt_g = COLOR_BITS'(v_cnt >> YSH);
                end
                default: ;
            endcase
        end
    end

    // en=0 behaves like a synchronous reset so a dropped frame restarts cleanly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_pix     <= '0;
            bar_idx     <= '0;
            pat_q       <= '0;
            hsync       <= (HSYNC_POL == 0);
            vsync       <= (VSYNC_POL == 0);
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (!en) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_pix     <= '0;
            bar_idx     <= '0;
            pat_q       <= '0;
            hsync       <= (HSYNC_POL == 0);
            vsync       <= (VSYNC_POL == 0);
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= (HSYNC_POL != 0) ? hs_on : !hs_on;
            vsync       <= (VSYNC_POL != 0) ? vs_on : !vs_on;
            blank       <= !active;
            x           <= h_cnt;
            y           <= v_cnt;
            red         <= nxt_r;
            green       <= nxt_g;
            blue        <= nxt_b;
            frame_start <= at_origin;
            line_start  <= (h_cnt == '0);
            if (at_origin) begin
                pat_q <= pattern_sel;
            end
            if (h_last) begin
                h_cnt   <= '0;
                bar_pix <= '0;
                bar_idx <= '0;
                v_cnt   <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (bar_pix == BAR_LAST) begin
                    bar_pix <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_pix <= bar_pix + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 24x12 raster: constant vector table,
// hand-written corner sequences and a randomized run against an arithmetic pixel model.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic [1:0] pattern_sel;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic [4:0] x;
    logic [3:0] y;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:0] blue;
    logic       frame_start;
    logic       line_start;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(1), .COLOR_BITS(3), .GRID_LOG2(2)
    ) dut (
        .clk(clk), .resetn(resetn), .en(en), .pattern_sel(pattern_sel),
        .hsync(hsync), .vsync(vsync), .blank(blank), .x(x), .y(y),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [4:0] px;
        logic [3:0] py;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       fs;
        logic       ls;
    } outs_t;

    typedef struct {
        logic [1:0] pat;
        int         px;
        int         py;
        outs_t      exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    function automatic outs_t mk(logic hs, logic vs, logic bl, int px, int py,
                                 int r, int g, int b, logic fs, logic ls);
        outs_t o;
        o.hs = hs;
        o.vs = vs;
        o.bl = bl;
        o.px = 5'(px);
        o.py = 4'(py);
        o.r  = 3'(r);
        o.g  = 3'(g);
        o.b  = 3'(b);
        o.fs = fs;
        o.ls = ls;
        return o;
    endfunction

    function automatic outs_t idleOuts();
        return mk(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endfunction

    // Reference pixel from the raster rules, addressed by linear pixel index within the frame.
    function automatic outs_t refPixel(int p, int pat);
        outs_t      o;
        int         px;
        int         py;
        logic [2:0] onoff;
        px = p % HT;
        py = p / HT;
        o = mk(!(px >= HA + HF && px < HA + HF + HS),
               (py >= VA + VF && py < VA + VF + VS),
               !(px < HA && py < VA), px, py, 0, 0, 0, (p == 0), (px == 0));
        if (!o.bl) begin
            case (pat)
                1: begin
                    onoff = 3'(7 - px / (HA / 8));
                    o.r = onoff[2] ? 3'd7 : 3'd0;
                    o.g = onoff[1] ? 3'd7 : 3'd0;
                    o.b = onoff[0] ? 3'd7 : 3'd0;
                end
                2: begin
                    if (px % 4 == 0 || py % 4 == 0) begin
                        o.r = 3'd7;
                        o.g = 3'd7;
                        o.b = 3'd7;
                    end
                end
                3: begin
                    o.r = 3'(px / 4);
                    o.g = 3'(py / 2);
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic outs_t dutOuts();
        return mk(hsync, vsync, blank, int'(x), int'(y), int'(red), int'(green), int'(blue),
                  frame_start, line_start);
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("hs=%0b vs=%0b bl=%0b x=%0d y=%0d rgb=%0d,%0d,%0d fs=%0b ls=%0b",
                         o.hs, o.vs, o.bl, o.px, o.py, o.r, o.g, o.b, o.fs, o.ls);
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t got;
        got = dutOuts();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] pat);
        en = e;
        pattern_sel = pat;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Restart the raster with the given pattern and stop with pixel p on the outputs.
    task automatic restartTo(input logic [1:0] pat, input int p);
        applyStimulus(1'b0, pat);
        stepEdge();
        applyStimulus(1'b1, pat);
        repeat (p + 1) stepEdge();
    endtask

    vec_t vecs[22];

    initial begin
        int    n;
        int    lsAt;
        int    lsCount;
        int    mp;
        int    mpat;
        int    roll;
        outs_t exp;

        vecs[0]  = '{2'd1, 0, 0,  mk(1, 0, 0, 0, 0, 7, 7, 7, 1, 1)};
        vecs[1]  = '{2'd1, 3, 2,  mk(1, 0, 0, 3, 2, 7, 7, 0, 0, 0)};
        vecs[2]  = '{2'd1, 5, 1,  mk(1, 0, 0, 5, 1, 7, 0, 7, 0, 0)};
        vecs[3]  = '{2'd1, 7, 6,  mk(1, 0, 0, 7, 6, 7, 0, 0, 0, 0)};
        vecs[4]  = '{2'd1, 9, 3,  mk(1, 0, 0, 9, 3, 0, 7, 7, 0, 0)};
        vecs[5]  = '{2'd1, 15, 7, mk(1, 0, 0, 15, 7, 0, 0, 0, 0, 0)};
        vecs[6]  = '{2'd1, 16, 0, mk(1, 0, 1, 16, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{2'd1, 0, 8,  mk(1, 0, 1, 0, 8, 0, 0, 0, 0, 1)};
        vecs[8]  = '{2'd0, 18, 2, mk(0, 0, 1, 18, 2, 0, 0, 0, 0, 0)};
        vecs[9]  = '{2'd0, 20, 3, mk(0, 0, 1, 20, 3, 0, 0, 0, 0, 0)};
        vecs[10] = '{2'd0, 17, 3, mk(1, 0, 1, 17, 3, 0, 0, 0, 0, 0)};
        vecs[11] = '{2'd0, 21, 3, mk(1, 0, 1, 21, 3, 0, 0, 0, 0, 0)};
        vecs[12] = '{2'd0, 0, 9,  mk(1, 1, 1, 0, 9, 0, 0, 0, 0, 1)};
        vecs[13] = '{2'd0, 23, 10, mk(1, 1, 1, 23, 10, 0, 0, 0, 0, 0)};
        vecs[14] = '{2'd0, 5, 8,  mk(1, 0, 1, 5, 8, 0, 0, 0, 0, 0)};
        vecs[15] = '{2'd0, 0, 11, mk(1, 0, 1, 0, 11, 0, 0, 0, 0, 1)};
        vecs[16] = '{2'd2, 4, 1,  mk(1, 0, 0, 4, 1, 7, 7, 7, 0, 0)};
        vecs[17] = '{2'd2, 5, 1,  mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0)};
        vecs[18] = '{2'd2, 5, 4,  mk(1, 0, 0, 5, 4, 7, 7, 7, 0, 0)};
        vecs[19] = '{2'd3, 12, 5, mk(1, 0, 0, 12, 5, 3, 2, 0, 0, 0)};
        vecs[20] = '{2'd3, 15, 7, mk(1, 0, 0, 15, 7, 3, 3, 0, 0, 0)};
        vecs[21] = '{2'd3, 16, 5, mk(1, 0, 1, 16, 5, 0, 0, 0, 0, 0)};

        // Power-up reset and first frame timing.
        resetn = 1'b1;
        applyStimulus(1'b0, 2'd0);
        #1 resetn = 1'b0;
        #1 checkOutput("reset_async", idleOuts());
        repeat (2) stepEdge();
        checkOutput("reset_hold", idleOuts());
        resetn = 1'b1;
        applyStimulus(1'b1, 2'd0);
        #1 checkOutput("reset_release", idleOuts());
        stepEdge();
        checkOutput("first_edge", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        n = 0;
        lsAt = -1;
        lsCount = 0;
        while (n < 400) begin
            stepEdge();
            n++;
            if (line_start) begin
                lsCount++;
                if (lsAt < 0) lsAt = n;
            end
            if (frame_start) break;
        end
        checkInt("frame_period", n, FT);
        checkInt("line_period", lsAt, HT);
        checkInt("lines_per_frame", lsCount, VT);

        $display("[TB] vector table");
        for (int i = 0; i < 22; i++) begin
            restartTo(vecs[i].pat, vecs[i].py * HT + vecs[i].px);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        $display("[TB] mid-frame pattern switch");
        restartTo(2'd1, 3 * HT);
        applyStimulus(1'b1, 2'd2);
        repeat (5 * HT + 5 - 3 * HT) stepEdge();
        checkOutput("switch_old_frame", mk(1, 0, 0, 5, 5, 7, 0, 7, 0, 0));
        repeat (FT - 5 * HT - 5) stepEdge();
        checkOutput("switch_new_origin", mk(1, 0, 0, 0, 0, 7, 7, 7, 1, 1));
        repeat (5 * HT + 5) stepEdge();
        checkOutput("switch_new_frame", mk(1, 0, 0, 5, 5, 0, 0, 0, 0, 0));

        $display("[TB] en drop mid-frame");
        restartTo(2'd0, 4 * HT + 7);
        checkOutput("pre_drop", mk(1, 0, 0, 7, 4, 0, 0, 0, 0, 0));
        applyStimulus(1'b0, 2'd0);
        stepEdge();
        checkOutput("en_drop_idle", idleOuts());
        applyStimulus(1'b1, 2'd0);
        stepEdge();
        checkOutput("en_recover_origin", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        stepEdge();
        checkOutput("en_recover_next", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        $display("[TB] reset pulse mid-frame");
        restartTo(2'd3, 2 * HT + 2);
        resetn = 1'b0;
        #1 checkOutput("reset_pulse_async", idleOuts());
        stepEdge();
        resetn = 1'b1;
        stepEdge();
        checkOutput("reset_recover_origin", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        stepEdge();
        checkOutput("reset_recover_next", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        $display("[TB] randomized run");
        applyStimulus(1'b0, 2'd0);
        stepEdge();
        mp = 0;
        mpat = 0;
        for (int i = 0; i < 6000; i++) begin
            roll = int'($urandom_range(0, 999));
            if ($urandom_range(0, 7) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if (roll < 2) begin
                resetn = 1'b0;
                #1 checkOutput("rand_reset_async", idleOuts());
                mp = 0;
                stepEdge();
                checkOutput("rand_reset_hold", idleOuts());
                resetn = 1'b1;
            end else begin
                en = (roll >= 5);
                @(posedge clk);
                if (!en) begin
                    exp = idleOuts();
                    mp = 0;
                end else begin
                    if (mp == 0) mpat = int'(pattern_sel);
                    exp = refPixel(mp, mpat);
                    mp = (mp + 1) % FT;
                end
                @(negedge clk);
                checkOutput("random", exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
